icache: RTL and testbench

Direct-mapped, read-only instruction cache between the instruction-fetch unit and the memory controller. It accepts one-cycle fetch pulses carrying a PC. It answers hits one cycle later. On a miss it refills a whole 4-word line through a word-wide request/done handshake, then returns the requested instruction with a one-cycle `have_result` pulse.

---
 rtl/icache_if.sv | 22 ++
 rtl/icache.sv | 110 +++++++++++
 tb/tb_icache.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/icache_if.sv
// Fetch-side and memory-side buses of the instruction cache.
// slave is the cache view; master is the fetch unit plus memory controller view.
interface icache_if;
    logic        req_in;
    logic [31:0] pc_in;
    logic        have_result;
    logic [31:0] inst_out;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_done;
    logic [31:0] mem_data;

    modport slave (
        input  req_in, pc_in, mem_done, mem_data,
        output have_result, inst_out, mem_req, mem_addr
    );

    modport master (
        output req_in, pc_in, mem_done, mem_data,
        input  have_result, inst_out, mem_req, mem_addr
    );
endinterface

// File: rtl/icache.sv
// Direct-mapped read-only icache, 16-byte lines refilled one word at a time from the line base.
// Hit answers 2 edges after the request; a miss answers one edge after the last word; rdy_in low freezes all state.
module icache #(
    parameter int INDEX_BITS = 4
) (
    input  logic    clk_in,
    input  logic    rst_in,
    input  logic    rdy_in,
    icache_if.slave bus
);
    localparam int LINES    = 1 << INDEX_BITS;
    localparam int TAG_BITS = 28 - INDEX_BITS;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;

    state_t              state_q;
    logic [31:2]         pc_q;
    logic [1:0]          cnt_q;
    logic                have_result_q;
    logic [31:0]         inst_q;
    logic                mem_req_q;
    logic [31:0]         mem_addr_q;
    logic [LINES-1:0]    valid_q;
    logic [TAG_BITS-1:0] tag_q  [LINES];
    logic [31:0]         data_q [LINES][4];

    logic [INDEX_BITS-1:0] idx;
    logic [TAG_BITS-1:0]   tag;
    logic [1:0]            wsel;
    logic                  hit;
    logic                  fill_we;

    assign idx     = pc_q[INDEX_BITS+3:4];
    assign tag     = pc_q[31:INDEX_BITS+4];
    assign wsel    = pc_q[3:2];
    assign hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign fill_we = rdy_in && !rst_in && (state_q == REFILL) && bus.mem_done;

    assign bus.have_result = have_result_q;
    assign bus.inst_out    = inst_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_addr    = mem_addr_q;

    // Tag and data storage is never reset; the valid bits alone decide hits.
    always_ff @(posedge clk_in) begin
        if (fill_we) begin
            data_q[idx][cnt_q] <= bus.mem_data;
            if (cnt_q == 2'd3) begin
                tag_q[idx] <= tag;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q       <= IDLE;
            pc_q          <= '0;
            cnt_q         <= 2'd0;
            have_result_q <= 1'b0;
            inst_q        <= 32'd0;
            mem_req_q     <= 1'b0;
            mem_addr_q    <= 32'd0;
            valid_q       <= '0;
        end else if (rdy_in) begin
            have_result_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (bus.req_in) begin
                        pc_q    <= bus.pc_in[31:2];
                        state_q <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        have_result_q <= 1'b1;
                        inst_q        <= data_q[idx][wsel];
                        state_q       <= IDLE;
                    end else begin
                        mem_req_q  <= 1'b1;
                        mem_addr_q <= {pc_q[31:4], 4'h0};
                        cnt_q      <= 2'd0;
                        state_q    <= REFILL;
                    end
                end
                REFILL: begin
                    if (bus.mem_done) begin
                        if (cnt_q == wsel) begin
                            inst_q <= bus.mem_data;
                        end
                        // A line being overwritten must not hit until its last word lands.
                        if (cnt_q == 2'd3) begin
                            valid_q[idx] <= 1'b1;
                            mem_req_q    <= 1'b0;
                            state_q      <= RESPOND;
                        end else begin
                            valid_q[idx] <= 1'b0;
                            cnt_q        <= cnt_q + 2'd1;
                            mem_addr_q   <= mem_addr_q + 32'd4;
                        end
                    end
                end
                RESPOND: begin
                    have_result_q <= 1'b1;
                    state_q       <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_icache.sv
// Bench for icache: directed scenarios then random fetches against a line-level model.
module tb_icache;
    logic clk_in = 1'b0;
    logic rst_in;
    logic rdy_in;

    icache_if bus ();

    icache #(.INDEX_BITS(4)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rdy_in (rdy_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    int vectors     = 0;
    int miscompares = 0;
    int mem_lat     = 3;
    int spur_req    = 0;
    int accepted    = 0;
    int hr_count    = 0;
    int exp_results = 0;
    logic [31:0] addr_log[$];

    // Reference model: which memory line each index holds, if any.
    bit          model_vld  [16];
    logic [27:0] model_line [16];

    // Memory controller: answers after mem_lat cycles, frozen while rdy_in is low.
    initial begin
        int  rcnt;
        int  spur_seen;
        bit  spur_active;
        rcnt = 0;
        spur_seen = 0;
        spur_active = 0;
        bus.mem_done = 1'b0;
        bus.mem_data = 32'd0;
        forever begin
            @(negedge clk_in);
            if (rst_in) begin
                bus.mem_done = 1'b0;
                spur_active = 0;
                rcnt = 0;
            end else if (rdy_in) begin
                if (bus.mem_done) begin
                    bus.mem_done = 1'b0;
                    if (!spur_active) accepted++;
                    spur_active = 0;
                    rcnt = 0;
                end else if (spur_seen != spur_req) begin
                    spur_seen = spur_req;
                    spur_active = 1;
                    bus.mem_done = 1'b1;
                    bus.mem_data = 32'hDEAD_BEEF;
                end else if (bus.mem_req) begin
                    rcnt++;
                    if (rcnt >= mem_lat) begin
                        bus.mem_done = 1'b1;
                        bus.mem_data = 32'hA000_0000 | bus.mem_addr;
                        addr_log.push_back(bus.mem_addr);
                    end
                end else begin
                    rcnt = 0;
                end
            end
        end
    end

    always @(negedge clk_in) begin
        if (bus.have_result === 1'b1) hr_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk_in);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) model_vld[i] = 0;
    endtask

    task automatic fetch(input logic [31:0] pc, input bit inject, input bit pause);
        int          idx;
        int          acc0;
        int          log0;
        int          n;
        bit          exp_hit;
        bit          paused;
        logic [31:0] base;
        logic [31:0] a0;
        logic [31:0] exp_inst;
        idx      = int'(pc[7:4]);
        base     = {pc[31:4], 4'h0};
        exp_inst = 32'hA000_0000 | {pc[31:2], 2'b00};
        exp_hit  = model_vld[idx] && (model_line[idx] == pc[31:4]);
        bus.req_in = 1'b1;
        bus.pc_in  = pc;
        step();
        bus.req_in = 1'b0;
        bus.pc_in  = $urandom;
        chk("lookup_have_result", {31'd0, bus.have_result}, 32'd0);
        chk("lookup_mem_req", {31'd0, bus.mem_req}, 32'd0);
        acc0 = accepted;
        log0 = addr_log.size();
        step();
        if (exp_hit) begin
            chk("hit_have_result", {31'd0, bus.have_result}, 32'd1);
            chk("hit_inst", bus.inst_out, exp_inst);
            chk("hit_mem_req", {31'd0, bus.mem_req}, 32'd0);
        end else begin
            chk("miss_mem_req", {31'd0, bus.mem_req}, 32'd1);
            chk("miss_base_addr", bus.mem_addr, base);
            n = 0;
            paused = 0;
            while (bus.have_result !== 1'b1 && n < 300) begin
                bus.req_in = inject && (n == 0);
                if (bus.req_in) bus.pc_in = pc ^ 32'h0000_0040;
                if (pause && !paused && bus.mem_done && (accepted - acc0 == 1)) begin
                    paused = 1;
                    a0 = bus.mem_addr;
                    rdy_in = 1'b0;
                    for (int p = 0; p < 5; p++) begin
                        step();
                        chk("pause_mem_addr", bus.mem_addr, a0);
                        chk("pause_mem_req", {31'd0, bus.mem_req}, 32'd1);
                        chk("pause_writes", accepted - acc0, 32'd1);
                    end
                    rdy_in = 1'b1;
                end
                step();
                n++;
            end
            bus.req_in = 1'b0;
            chk("refill_have_result", {31'd0, bus.have_result}, 32'd1);
            chk("refill_inst", bus.inst_out, exp_inst);
            chk("refill_mem_req", {31'd0, bus.mem_req}, 32'd0);
            chk("refill_writes", accepted - acc0, 32'd4);
            chk("refill_addr_count", addr_log.size() - log0, 32'd4);
            for (int i = 0; i < 4 && log0 + i < addr_log.size(); i++) begin
                chk("refill_addr", addr_log[log0 + i], base + 32'(4 * i));
            end
            if (pause) chk("pause_taken", {31'd0, paused}, 32'd1);
            model_vld[idx]  = 1;
            model_line[idx] = pc[31:4];
        end
        exp_results++;
        step();
        chk("pulse_width", {31'd0, bus.have_result}, 32'd0);
        chk("result_count", hr_count, exp_results);
        chk("inst_hold", bus.inst_out, exp_inst);
    endtask

    initial begin
        int          acc0;
        int          n;
        logic [31:0] rpc;
        rst_in     = 1'b1;
        rdy_in     = 1'b1;
        bus.req_in = 1'b0;
        bus.pc_in  = 32'd0;
        model_reset();
        step();
        step();
        rst_in = 1'b0;
        chk("reset_have_result", {31'd0, bus.have_result}, 32'd0);
        chk("reset_inst", bus.inst_out, 32'd0);
        chk("reset_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("reset_mem_addr", bus.mem_addr, 32'd0);

        mem_lat = 3;
        fetch(32'h0000_0008, 0, 0);
        fetch(32'h0000_0004, 0, 0);
        fetch(32'h0000_0100, 0, 0);
        fetch(32'h0000_0000, 0, 0);
        fetch(32'h0000_0030, 0, 1);

        // Reset after two words of a refill must abort it cleanly.
        acc0 = accepted;
        bus.req_in = 1'b1;
        bus.pc_in  = 32'h0000_0020;
        step();
        bus.req_in = 1'b0;
        n = 0;
        while (accepted - acc0 < 2 && n < 100) begin
            step();
            n++;
        end
        chk("abort_progress", accepted - acc0, 32'd2);
        rst_in = 1'b1;
        step();
        rst_in = 1'b0;
        model_reset();
        chk("abort_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("abort_mem_addr", bus.mem_addr, 32'd0);
        chk("abort_inst", bus.inst_out, 32'd0);
        repeat (8) step();
        chk("abort_no_result", hr_count, exp_results);
        chk("abort_idle_mem_req", {31'd0, bus.mem_req}, 32'd0);
        fetch(32'h0000_0020, 0, 0);

        // Stray mem_done while idle is ignored.
        spur_req++;
        repeat (4) step();
        chk("spur_no_result", hr_count, exp_results);
        chk("spur_mem_req", {31'd0, bus.mem_req}, 32'd0);
        chk("spur_inst", bus.inst_out, 32'hA000_0020);
        fetch(32'h0000_0020, 0, 0);
        fetch(32'h0000_0028, 0, 0);
        fetch(32'h0000_0044, 1, 0);
        fetch(32'h0000_0004, 0, 0);

        for (int r = 0; r < 40; r++) begin
            mem_lat = $urandom_range(1, 4);
            rpc = {1'($urandom_range(0, 1)), 21'h0, 2'($urandom_range(0, 2)),
                   4'($urandom_range(0, 15)), 4'($urandom)};
            fetch(rpc, (r % 7) == 0, (r % 9) == 4);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
